// File: rtl/mc_regfile_xbus_if.sv
// ---------------------------------------------------------------------------
// mc_regfile_xbus_if
// Bus bundle between the MC decode/execute stage (plus pins and XBus partners)
// and the MC register file.
//   write_en/write_addr/write_dat   core write request
//   read_en0/1, read_addr0/1        core read requests, two ports
//   dat_out0/1                      read data back to the core
//   stall                           core must hold its request this cycle
//   p_in/p_out                      simple-I/O pins, pin k at [k*DW +: DW]
//   x_in_dat/x_in_valid/x_in_ready  XBus receive side, one lane per channel
//   x_out_dat/x_out_valid/x_out_ready XBus transmit side, one lane per channel
// Modports: slave = register file, master = core/pins/partners.
// ---------------------------------------------------------------------------
interface mc_regfile_xbus_if #(
  parameter int DW = 11,
  parameter int NP = 2,
  parameter int NX = 2,
  parameter int AW = 4
);
  logic              write_en;
  logic [AW-1:0]     write_addr;
  logic [DW-1:0]     write_dat;
  logic              read_en0;
  logic              read_en1;
  logic [AW-1:0]     read_addr0;
  logic [AW-1:0]     read_addr1;
  logic [DW-1:0]     dat_out0;
  logic [DW-1:0]     dat_out1;
  logic              stall;
  logic [NP*DW-1:0]  p_in;
  logic [NP*DW-1:0]  p_out;
  logic [NX*DW-1:0]  x_in_dat;
  logic [NX-1:0]     x_in_valid;
  logic [NX-1:0]     x_in_ready;
  logic [NX*DW-1:0]  x_out_dat;
  logic [NX-1:0]     x_out_valid;
  logic [NX-1:0]     x_out_ready;

  modport slave (
    input  write_en, write_addr, write_dat,
    input  read_en0, read_en1, read_addr0, read_addr1,
    output dat_out0, dat_out1, stall,
    input  p_in,
    output p_out,
    input  x_in_dat, x_in_valid,
    output x_in_ready,
    output x_out_dat, x_out_valid,
    input  x_out_ready
  );

  modport master (
    output write_en, write_addr, write_dat,
    output read_en0, read_en1, read_addr0, read_addr1,
    input  dat_out0, dat_out1, stall,
    output p_in,
    input  p_out,
    output x_in_dat, x_in_valid,
    input  x_in_ready,
    input  x_out_dat, x_out_valid,
    output x_out_ready
  );
endinterface

// File: rtl/mc_regfile_xbus.sv
// ---------------------------------------------------------------------------
// mc_regfile_xbus
// MC-series register file: acc/dat general registers, NP simple-I/O pins and
// NX blocking XBus channels, with value saturation and a core stall.
// Address map: 0=acc, 1=dat, 2..1+NP = p0.., 2+NP..1+NP+NX = x0..;
// unmapped reads return 0, unmapped writes are dropped.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mc_regfile_xbus_if.slave (core request/response, pins, XBus)
// Requires 2+NP+NX <= 2**AW.
// ---------------------------------------------------------------------------
module mc_regfile_xbus #(
  parameter int DW   = 11,
  parameter int NP   = 2,
  parameter int NX   = 2,
  parameter int AW   = 4,
  parameter int VMAX = 999,
  parameter int PMAX = 100
) (
  input logic                clk,
  input logic                rst_n,
  mc_regfile_xbus_if.slave   bus
);

  localparam logic [AW-1:0]        ADDR_ACC = AW'(0);
  localparam logic [AW-1:0]        ADDR_DAT = AW'(1);
  localparam int                   P_BASE   = 2;
  localparam int                   X_BASE   = 2 + NP;
  localparam logic signed [DW-1:0] VMAX_C   = DW'(VMAX);
  localparam logic signed [DW-1:0] VMIN_C   = DW'(-VMAX);
  localparam logic signed [DW-1:0] PMAX_C   = DW'(PMAX);
  localparam logic signed [DW-1:0] ZERO_C   = {DW{1'b0}};

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_e;

  // Clamp a register/XBus value to [-VMAX, VMAX].
  function automatic logic [DW-1:0] sat_reg(input logic [DW-1:0] v);
    logic signed [DW-1:0] s;
    s = $signed(v);
    if (s > VMAX_C) begin
      return VMAX_C;
    end else if (s < VMIN_C) begin
      return VMIN_C;
    end else begin
      return v;
    end
  endfunction

  // Clamp a simple-I/O output value to [0, PMAX].
  function automatic logic [DW-1:0] sat_pin(input logic [DW-1:0] v);
    logic signed [DW-1:0] s;
    s = $signed(v);
    if (s < ZERO_C) begin
      return ZERO_C;
    end else if (s > PMAX_C) begin
      return PMAX_C;
    end else begin
      return v;
    end
  endfunction

  // Combinational read mux for one port; disabled or unmapped reads give 0.
  function automatic logic [DW-1:0] read_mux(
    input logic             en,
    input logic [AW-1:0]    addr,
    input logic [DW-1:0]    acc,
    input logic [DW-1:0]    dat,
    input logic [NP*DW-1:0] pins,
    input logic [NX*DW-1:0] xd
  );
    logic [DW-1:0] r;
    r = {DW{1'b0}};
    if (!en) begin
      r = {DW{1'b0}};
    end else if (addr == ADDR_ACC) begin
      r = acc;
    end else if (addr == ADDR_DAT) begin
      r = dat;
    end else begin
      for (int k = 0; k < NP; k++) begin
        r = (addr == AW'(P_BASE + k)) ? pins[k*DW +: DW] : r;
      end
      for (int k = 0; k < NX; k++) begin
        r = (addr == AW'(X_BASE + k)) ? xd[k*DW +: DW] : r;
      end
    end
    return r;
  endfunction

  logic [DW-1:0]    acc_q, acc_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic [NP*DW-1:0] p_out_q, p_out_d;
  logic [NX*DW-1:0] x_out_dat_q, x_out_dat_d;
  tx_state_e        tx_q [NX];

  logic             wr_acc_s, wr_dat_s;
  logic [NP-1:0]    wr_p_s, rd_p_s;
  logic [NX-1:0]    wr_x_s, rd_x0_s, rd_x1_s, rd_x_s, pend_s;
  logic             stall_s;

  // Address decode of the write port and both read ports.
  always_comb begin
    wr_acc_s = bus.write_en && (bus.write_addr == ADDR_ACC);
    wr_dat_s = bus.write_en && (bus.write_addr == ADDR_DAT);
    wr_p_s   = '0;
    rd_p_s   = '0;
    wr_x_s   = '0;
    rd_x0_s  = '0;
    rd_x1_s  = '0;
    for (int k = 0; k < NP; k++) begin
      wr_p_s[k] = bus.write_en && (bus.write_addr == AW'(P_BASE + k));
      rd_p_s[k] = (bus.read_en0 && (bus.read_addr0 == AW'(P_BASE + k))) ||
                  (bus.read_en1 && (bus.read_addr1 == AW'(P_BASE + k)));
    end
    for (int k = 0; k < NX; k++) begin
      wr_x_s[k]  = bus.write_en && (bus.write_addr == AW'(X_BASE + k));
      rd_x0_s[k] = bus.read_en0 && (bus.read_addr0 == AW'(X_BASE + k));
      rd_x1_s[k] = bus.read_en1 && (bus.read_addr1 == AW'(X_BASE + k));
    end
  end

  // Channel pending flags straight from the transmit state flops.
  always_comb begin
    pend_s = '0;
    for (int k = 0; k < NX; k++) begin
      pend_s[k] = (tx_q[k] == TX_PEND);
    end
  end

  // Stall uses only PEND state, read requests and x_in_valid, so there is
  // no combinational path from x_out_ready into the core.
  assign rd_x_s  = rd_x0_s | rd_x1_s;
  assign stall_s = (|pend_s) | (|(rd_x_s & ~bus.x_in_valid));

  // Next-state for data registers; nothing commits while stalled.
  always_comb begin
    acc_d       = acc_q;
    dat_d       = dat_q;
    p_out_d     = p_out_q;
    x_out_dat_d = x_out_dat_q;
    if (!stall_s) begin
      if (wr_acc_s) begin
        acc_d = sat_reg(bus.write_dat);
      end else begin
        acc_d = acc_q;
      end
      if (wr_dat_s) begin
        dat_d = sat_reg(bus.write_dat);
      end else begin
        dat_d = dat_q;
      end
      // A write to a pin takes priority over the read-clear of that pin.
      for (int k = 0; k < NP; k++) begin
        if (wr_p_s[k]) begin
          p_out_d[k*DW +: DW] = sat_pin(bus.write_dat);
        end else if (rd_p_s[k]) begin
          p_out_d[k*DW +: DW] = {DW{1'b0}};
        end else begin
          p_out_d[k*DW +: DW] = p_out_q[k*DW +: DW];
        end
      end
      // A committed XBus write only happens from IDLE: PEND forces stall.
      for (int k = 0; k < NX; k++) begin
        if (wr_x_s[k]) begin
          x_out_dat_d[k*DW +: DW] = sat_reg(bus.write_dat);
        end else begin
          x_out_dat_d[k*DW +: DW] = x_out_dat_q[k*DW +: DW];
        end
      end
    end else begin
      acc_d       = acc_q;
      dat_d       = dat_q;
      p_out_d     = p_out_q;
      x_out_dat_d = x_out_dat_q;
    end
  end

  // Data register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= {DW{1'b0}};
      dat_q       <= {DW{1'b0}};
      p_out_q     <= {(NP*DW){1'b0}};
      x_out_dat_q <= {(NX*DW){1'b0}};
    end else begin
      acc_q       <= acc_d;
      dat_q       <= dat_d;
      p_out_q     <= p_out_d;
      x_out_dat_q <= x_out_dat_d;
    end
  end

  // Per-channel XBus transmit FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NX; k++) begin
        tx_q[k] <= TX_IDLE;
      end
    end else begin
      for (int k = 0; k < NX; k++) begin
        case (tx_q[k])
          TX_IDLE: begin
            if (wr_x_s[k] && !stall_s) begin
              tx_q[k] <= TX_PEND;
            end else begin
              tx_q[k] <= TX_IDLE;
            end
          end
          TX_PEND: begin
            if (bus.x_out_ready[k]) begin
              tx_q[k] <= TX_IDLE;
            end else begin
              tx_q[k] <= TX_PEND;
            end
          end
          default: tx_q[k] <= TX_IDLE;
        endcase
      end
    end
  end

  // Both ports reading the same channel share a single consume pulse.
  assign bus.x_in_ready  = rd_x_s & bus.x_in_valid & {NX{~stall_s}};
  assign bus.stall       = stall_s;
  assign bus.dat_out0    = read_mux(bus.read_en0, bus.read_addr0, acc_q, dat_q,
                                    bus.p_in, bus.x_in_dat);
  assign bus.dat_out1    = read_mux(bus.read_en1, bus.read_addr1, acc_q, dat_q,
                                    bus.p_in, bus.x_in_dat);
  assign bus.p_out       = p_out_q;
  assign bus.x_out_dat   = x_out_dat_q;
  assign bus.x_out_valid = pend_s;

endmodule
